tx_word_fifo: RTL and testbench
===============================

// Module: tx_word_fifo
// PURPOSE
//  Transmit-side word buffer in the clk_tx domain, directly upstream of the fast 4-phase synchronizer.
//  Accepts words from the local producer into a circular FIFO.
//  Presents one word at a time on indata/vi and holds it until the synchronizer returns snt.
//  Decouples producer bursts from the synchronizer's round-trip latency.
// PARAMETERS
//  DATA_MSB    7   MSB index of data word (width DATA_MSB+1), matches synchronizer data path
//  ADDR_W      3   FIFO address bits; DEPTH = 2**ADDR_W entries
//  CNT_W       16  width of sent_cnt statistics counter
// PORTS
//  clk_tx      in   1           transmit-domain clock, all logic rising-edge
//  reset       in   1           asynchronous, active-high reset
//  wr_en       in   1           producer write strobe
//  wr_data     in   DATA_MSB+1  producer data word
//  full        out  1           FIFO holds DEPTH words; writes are dropped
//  empty       out  1           FIFO holds 0 words
//  count       out  ADDR_W+1    current occupancy, 0..DEPTH
//  ovf         out  1           sticky: a write was attempted while full
//  spur        out  1           sticky: snt seen while vi low
//  vi          out  1           word valid to synchronizer
//  indata      out  DATA_MSB+1  word to synchronizer, stable while vi=1
//  snt         in   1           one-cycle pulse from synchronizer: presented word consumed
//  sent_cnt    out  CNT_W       words delivered, wraps modulo 2**CNT_W
// BEHAVIOUR
//  Reset (async, immediate):
//   - vi, indata, count, ovf, spur, sent_cnt, rd_ptr, wr_ptr all 0; empty=1, full=0.
//   - State is IDLE. Memory contents are don't-care.
//  Storage:
//   - wr_ptr and rd_ptr are ADDR_W bits and wrap naturally.
//   - full = (count==DEPTH); empty = (count==0); both decoded from registered count.
//   - Write accepted iff wr_en && !full: mem[wr_ptr] <= wr_data; wr_ptr++.
//   - wr_en && full: word dropped, no state change, ovf <= 1 until reset.
//  Pop on snt in SEND: rd_ptr++.
//  Count update: +1 on accepted write, -1 on pop, unchanged when both occur in the same cycle.
//  Transmit FSM (registered outputs):
//   - IDLE: vi=0. If count!=0: indata <= mem[rd_ptr], vi <= 1, go to SEND.
//   - SEND: vi=1, indata held constant.
//     - On snt: vi <= 0, pop, sent_cnt++, go to GAP.
//     - Otherwise stay in SEND indefinitely; there is no timeout.
//   - GAP: vi=0 for exactly one cycle (return-to-zero for the 4-phase link), then go to IDLE.
//  Latency:
//   - Write accepted at edge N into an empty FIFO in IDLE: vi=1 after edge N+1.
//   - Back-to-back words: snt at edge M -> vi low after M, high again after M+2.
//   - Per-word vi period is therefore 3 cycles plus the synchronizer round trip.
//  Boundaries:
//   - Write to full in the same cycle as a pop: the write is still dropped, because full is registered.
//   - snt in IDLE or GAP: ignored for data, spur <= 1.
//   - Write during SEND does not disturb indata.
//   - Reset mid-SEND: vi drops asynchronously; the in-flight word is lost.
// TESTING
//  1. Reset, write 0xA5 once -> vi=1 with indata=0xA5 two edges after write.
//     Then snt pulse -> vi=0, count=0, sent_cnt=1.
//  2. Write 8 words 0x00..0x07 back-to-back with snt withheld -> full=1, count=8.
//     9th write -> ovf=1, count stays 8.
//  3. Drain case 2 with snt one cycle after each vi rise.
//     -> indata sequence 0x00..0x07 in order, one GAP cycle between words, empty=1 at end.
//  4. Write and snt-pop in the same cycle with count=3 -> count stays 3; ptr wrap past entry 7 preserves order.
//  5. snt pulse while idle and empty -> spur=1, count and sent_cnt unchanged.
//  6. Assert reset while vi=1 with count=4 -> vi, count and sent_cnt = 0 immediately.
//     Next write is presented normally.

Source files
------------

// File: rtl/tx_word_fifo.sv
// Transmit-side circular word buffer feeding the 4-phase synchronizer.
// Presents one word on indata/vi until snt, then returns vi to zero for one cycle.
module tx_word_fifo #(
   parameter int DATA_MSB = 7,
   parameter int ADDR_W   = 3,
   parameter int CNT_W    = 16
) (
   input  logic                clk_tx,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [DATA_MSB:0]   wr_data,
   output logic                full,
   output logic                empty,
   output logic [ADDR_W:0]     count,
   output logic                ovf,
   output logic                spur,
   output logic                vi,
   output logic [DATA_MSB:0]   indata,
   input  logic                snt,
   output logic [CNT_W-1:0]    sent_cnt
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } txState_e;

   txState_e              state_q;
   logic [DATA_MSB:0]     mem_q [DEPTH];
   logic [ADDR_W-1:0]     wrPtr_q, rdPtr_q;
   logic [ADDR_W:0]       count_q, count_d;
   logic                  ovf_q, spur_q, vi_q;
   logic [DATA_MSB:0]     indata_q;
   logic [CNT_W-1:0]      sentCnt_q;
   logic                  wrAccept, pop;

   // full/empty come from the registered count, so a pop cannot make room for a same-cycle write
   assign full     = (count_q == DEPTH_C);
   assign empty    = (count_q == '0);
   assign wrAccept = wr_en && !full;
   assign pop      = (state_q == SEND) && snt;

   always_comb begin
      count_d = count_q;
      if (wrAccept && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (!wrAccept && pop) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk_tx) begin
      if (wrAccept) begin
         mem_q[wrPtr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk_tx or posedge reset) begin
      if (reset) begin
         wrPtr_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         spur_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         if (wrAccept) begin
            wrPtr_q <= wrPtr_q + ADDR_W'(1);
         end
         if (wr_en && full) begin
            ovf_q <= 1'b1;
         end
         if (snt && (state_q != SEND)) begin
            spur_q <= 1'b1;
         end
      end
   end

   // GAP holds vi low for one cycle so the 4-phase link sees a return-to-zero between words
   always_ff @(posedge clk_tx or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         vi_q      <= 1'b0;
         indata_q  <= '0;
         rdPtr_q   <= '0;
         sentCnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               vi_q <= 1'b0;
               if (count_q != '0) begin
                  indata_q <= mem_q[rdPtr_q];
                  vi_q     <= 1'b1;
                  state_q  <= SEND;
               end
            end
            SEND: begin
               if (snt) begin
                  vi_q      <= 1'b0;
                  rdPtr_q   <= rdPtr_q + ADDR_W'(1);
                  sentCnt_q <= sentCnt_q + CNT_W'(1);
                  state_q   <= GAP;
               end
            end
            GAP: begin
               vi_q    <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               vi_q    <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign count    = count_q;
   assign ovf      = ovf_q;
   assign spur     = spur_q;
   assign vi       = vi_q;
   assign indata   = indata_q;
   assign sent_cnt = sentCnt_q;

endmodule

// File: tb/tb_tx_word_fifo.sv
// Directed self-checking bench for tx_word_fifo: one task per scenario,
// inputs driven 1 time unit after each rising edge and outputs sampled there too.
module tb_tx_word_fifo;

   logic        clk_tx;
   logic        reset;
   logic        wr_en;
   logic [7:0]  wr_data;
   logic        full;
   logic        empty;
   logic [3:0]  count;
   logic        ovf;
   logic        spur;
   logic        vi;
   logic [7:0]  indata;
   logic        snt;
   logic [15:0] sent_cnt;

   int checks = 0;
   int errors = 0;

   tx_word_fifo #(.DATA_MSB(7), .ADDR_W(3), .CNT_W(16)) dut (
      .clk_tx   (clk_tx),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .ovf      (ovf),
      .spur     (spur),
      .vi       (vi),
      .indata   (indata),
      .snt      (snt),
      .sent_cnt (sent_cnt)
   );

   // Free-running transmit clock, 10 time units per period
   initial begin
      clk_tx = 1'b0;
      forever #5 clk_tx = ~clk_tx;
   end

   // Hard stop in case something upstream never returns
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk_tx);
      #1;
   endtask

   task automatic sntPulse();
      snt = 1'b1;
      tick();
      snt = 1'b0;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      snt     = 1'b0;
      repeat (2) tick();
      checks++;
      if (vi !== 1'b0 || count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: vi=%b count=%0d empty=%b full=%b, want 0 0 1 0", vi, count, empty, full);
      end
      checks++;
      if (ovf !== 1'b0 || spur !== 1'b0 || sent_cnt !== 16'd0 || indata !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_regs: ovf=%b spur=%b sent_cnt=%0d indata=%h, want 0 0 0 00", ovf, spur, sent_cnt, indata);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_word();
      wr_en   = 1'b1;
      wr_data = 8'hA5;
      tick();
      wr_en = 1'b0;
      checks++;
      if (count !== 4'd1 || vi !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_after_write: count=%0d vi=%b, want 1 0", count, vi);
      end
      tick();
      checks++;
      if (vi !== 1'b1 || indata !== 8'hA5) begin
         errors++;
         $display("[TB] FAIL single_present: vi=%b indata=%h, want 1 a5", vi, indata);
      end
      sntPulse();
      checks++;
      if (vi !== 1'b0 || count !== 4'd0 || sent_cnt !== 16'd1 || empty !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_pop: vi=%b count=%0d sent_cnt=%0d empty=%b, want 0 0 1 1", vi, count, sent_cnt, empty);
      end
      repeat (2) tick();
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 8; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'(i);
         tick();
      end
      checks++;
      if (full !== 1'b1 || count !== 4'd8 || ovf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fill_full: full=%b count=%0d ovf=%b, want 1 8 0", full, count, ovf);
      end
      wr_data = 8'hFF;
      tick();
      wr_en = 1'b0;
      checks++;
      if (ovf !== 1'b1 || count !== 4'd8 || full !== 1'b1) begin
         errors++;
         $display("[TB] FAIL fill_overflow: ovf=%b count=%0d full=%b, want 1 8 1", ovf, count, full);
      end
      checks++;
      if (vi !== 1'b1 || indata !== 8'h00) begin
         errors++;
         $display("[TB] FAIL fill_hold: vi=%b indata=%h, want 1 00", vi, indata);
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (vi !== 1'b1 || indata !== 8'(i)) begin
            errors++;
            $display("[TB] FAIL drain_word%0d: vi=%b indata=%h, want 1 %h", i, vi, indata, 8'(i));
         end
         sntPulse();
         checks++;
         if (vi !== 1'b0 || count !== 4'(7 - i)) begin
            errors++;
            $display("[TB] FAIL drain_pop%0d: vi=%b count=%0d, want 0 %0d", i, vi, count, 7 - i);
         end
         tick();
         checks++;
         if (vi !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_gap%0d: vi=%b, want 0", i, vi);
         end
         tick();
      end
      checks++;
      if (empty !== 1'b1 || vi !== 1'b0 || sent_cnt !== 16'd9) begin
         errors++;
         $display("[TB] FAIL drain_end: empty=%b vi=%b sent_cnt=%0d, want 1 0 9", empty, vi, sent_cnt);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 7; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'h10 + 8'(i);
         tick();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (vi !== 1'b1 || indata !== 8'h10 + 8'(i)) begin
            errors++;
            $display("[TB] FAIL b2b_first%0d: vi=%b indata=%h, want 1 %h", i, vi, indata, 8'h10 + 8'(i));
         end
         sntPulse();
         repeat (2) tick();
      end
      checks++;
      if (count !== 4'd3 || vi !== 1'b1 || indata !== 8'h14) begin
         errors++;
         $display("[TB] FAIL b2b_pre: count=%0d vi=%b indata=%h, want 3 1 14", count, vi, indata);
      end
      wr_en   = 1'b1;
      wr_data = 8'h17;
      snt     = 1'b1;
      tick();
      wr_en = 1'b0;
      snt   = 1'b0;
      checks++;
      if (count !== 4'd3 || vi !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_simul: count=%0d vi=%b, want 3 0", count, vi);
      end
      repeat (2) tick();
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (vi !== 1'b1 || indata !== 8'h15 + 8'(j)) begin
            errors++;
            $display("[TB] FAIL b2b_wrap%0d: vi=%b indata=%h, want 1 %h", j, vi, indata, 8'h15 + 8'(j));
         end
         sntPulse();
         repeat (2) tick();
      end
      checks++;
      if (empty !== 1'b1 || sent_cnt !== 16'd17) begin
         errors++;
         $display("[TB] FAIL b2b_end: empty=%b sent_cnt=%0d, want 1 17", empty, sent_cnt);
      end
   endtask

   task automatic test_spurious();
      checks++;
      if (spur !== 1'b0) begin
         errors++;
         $display("[TB] FAIL spur_before: spur=%b, want 0", spur);
      end
      sntPulse();
      checks++;
      if (spur !== 1'b1 || count !== 4'd0 || sent_cnt !== 16'd17 || vi !== 1'b0) begin
         errors++;
         $display("[TB] FAIL spur_after: spur=%b count=%0d sent_cnt=%0d vi=%b, want 1 0 17 0", spur, count, sent_cnt, vi);
      end
      tick();
   endtask

   task automatic test_reset_mid_send();
      for (int i = 0; i < 4; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'h30 + 8'(i);
         tick();
      end
      wr_en = 1'b0;
      checks++;
      if (vi !== 1'b1 || count !== 4'd4 || indata !== 8'h30) begin
         errors++;
         $display("[TB] FAIL midrst_pre: vi=%b count=%0d indata=%h, want 1 4 30", vi, count, indata);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (vi !== 1'b0 || count !== 4'd0 || sent_cnt !== 16'd0 || ovf !== 1'b0 || spur !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_async: vi=%b count=%0d sent_cnt=%0d ovf=%b spur=%b, want 0 0 0 0 0", vi, count, sent_cnt, ovf, spur);
      end
      #1;
      reset = 1'b0;
      tick();
      wr_en   = 1'b1;
      wr_data = 8'h40;
      tick();
      wr_en = 1'b0;
      tick();
      checks++;
      if (vi !== 1'b1 || indata !== 8'h40 || count !== 4'd1) begin
         errors++;
         $display("[TB] FAIL midrst_resume: vi=%b indata=%h count=%0d, want 1 40 1", vi, indata, count);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_fill_overflow();
      test_drain();
      test_back_to_back();
      test_spurious();
      test_reset_mid_send();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
